ball_court_ctrl: RTL



---
 rtl/tennis_pkg.sv | 25 ++
 rtl/step_tick_gen.sv | 40 ++++
 rtl/ball_court_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/tennis_pkg.sv
// -----------------------------------------------------------------------------
// tennis_pkg
//   Shared types and defaults for the court/ball controller and its players.
//   - court_state_e : rally state (IDLE, MOVE_R, MOVE_L, POINT)
//   - DIR_LEFT/RIGHT: encoding of the dir output
//   - DEF_*         : default court geometry and timing
// -----------------------------------------------------------------------------
package tennis_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_R = 2'd1,
    MOVE_L = 2'd2,
    POINT  = 2'd3
  } court_state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int DEF_NUM_POS  = 8;
  localparam int DEF_TICK_DIV = 25_000_000;
  localparam int DEF_HIT_WIN  = 1;
  localparam int DEF_MIN_DIV  = 2_500_000;

endpackage

// File: rtl/step_tick_gen.sv
// -----------------------------------------------------------------------------
// step_tick_gen
//   Ball step timer. Counts clk cycles and raises strobe for one cycle when
//   the count reaches period-1, then reloads to 0.
//   Ports:
//     clk, rst (async, active-high)
//     period  [PW] : cycles per step (sampled every cycle)
//     clear        : restart the step interval from 0
//     enable       : count only while high; held at 0 otherwise
//     strobe       : single-cycle step pulse
// -----------------------------------------------------------------------------
module step_tick_gen #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] period,
  input  logic          clear,
  input  logic          enable,
  output logic          strobe
);

  logic [PW-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    strobe  = enable && (count_q == period - PW'(1));
    count_d = count_q + PW'(1);
    if (clear || !enable || strobe) count_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state flops use non-blocking assignment so every flop samples the
    // pre-edge values regardless of process ordering.
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/ball_court_ctrl.sv
// -----------------------------------------------------------------------------
// ball_court_ctrl
//   Court/ball controller for one two-player game. Serves the ball, steps it
//   across NUM_POS LEDs, opens the per-player hit windows, accepts returns and
//   resolves rallies into point pulses.
//   Ports:
//     clk, rst (async, active-high)
//     serve                : one-cycle serve pulse, honoured only in IDLE
//     return_l/return_r    : player return pulses
//     match_l/match_r      : player rally-lost indications
//     start_game           : rally live
//     hittable_l/r         : ball inside that player's hit window
//     ball_pos [NUM_POS]   : one-hot ball LED, bit 0 = left end
//     dir                  : 0 = moving left, 1 = moving right
//     point_l/point_r      : one-cycle rally-won pulses
//   All outputs are registered from the next-state values.
//   Build option: define COURT_SPEEDUP_EN to shorten the step period by 1/8 on
//   every accepted return, floored at MIN_DIV.
// -----------------------------------------------------------------------------
module ball_court_ctrl
  import tennis_pkg::*;
#(
  parameter int NUM_POS  = DEF_NUM_POS,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int HIT_WIN  = DEF_HIT_WIN,
  parameter int MIN_DIV  = DEF_MIN_DIV
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               serve,
  input  logic               return_l,
  input  logic               return_r,
  input  logic               match_l,
  input  logic               match_r,
  output logic               start_game,
  output logic               hittable_l,
  output logic               hittable_r,
  output logic [NUM_POS-1:0] ball_pos,
  output logic               dir,
  output logic               point_l,
  output logic               point_r
);

  localparam int PW = $clog2(TICK_DIV) + 1;
  localparam int XW = $clog2(NUM_POS);

  localparam logic [XW-1:0] POS_MAX    = XW'(NUM_POS - 1);
  localparam logic [XW-1:0] WIN_R      = XW'(NUM_POS - HIT_WIN);
  localparam logic [XW-1:0] WIN_L      = XW'(HIT_WIN);
  localparam logic [PW-1:0] PERIOD_RST = PW'(TICK_DIV);

  // A floor above the reset period would make returns slow the ball down.
  if (MIN_DIV > TICK_DIV) begin : g_min_div_above_tick_div
  end

  court_state_e state_q, state_d;
  logic [XW-1:0] pos_q, pos_d;
  logic [PW-1:0] period;
  logic          strobe, clear, ret_ok, win_l, win_r, live_d;

  logic               start_game_q, start_game_d;
  logic               hittable_l_q, hittable_l_d;
  logic               hittable_r_q, hittable_r_d;
  logic [NUM_POS-1:0] ball_pos_q, ball_pos_d;
  logic               dir_q, dir_d;
  logic               point_l_q, point_l_d;
  logic               point_r_q, point_r_d;

  step_tick_gen #(.PW(PW)) u_step (
    .clk    (clk),
    .rst    (rst),
    .period (period),
    .clear  (clear),
    .enable (state_q == MOVE_R || state_q == MOVE_L),
    .strobe (strobe)
  );

  // Next state. Priority inside a live rally: match, then return, then strobe,
  // so a return landing on the terminal strobe bounces the ball.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    clear   = 1'b0;
    ret_ok  = 1'b0;
    win_l   = 1'b0;
    win_r   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (serve) begin
          state_d = MOVE_R;
          pos_d   = '0;
          clear   = 1'b1;
        end
      end
      MOVE_R, MOVE_L: begin
        if (match_l || match_r) begin
          state_d = POINT;
          win_l   = match_r && !match_l;
          win_r   = match_l && !match_r;
        end else if (state_q == MOVE_R && return_r && hittable_r_q) begin
          state_d = MOVE_L;
          clear   = 1'b1;
          ret_ok  = 1'b1;
        end else if (state_q == MOVE_L && return_l && hittable_l_q) begin
          state_d = MOVE_R;
          clear   = 1'b1;
          ret_ok  = 1'b1;
        end else if (strobe) begin
          if (state_q == MOVE_R) begin
            if (pos_q == POS_MAX) begin
              state_d = POINT;
              win_l   = 1'b1;
            end else begin
              pos_d = pos_q + XW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              state_d = POINT;
              win_r   = 1'b1;
            end else begin
              pos_d = pos_q - XW'(1);
            end
          end
        end
      end
      POINT: begin
        state_d = IDLE;
        pos_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they appear registered, one cycle
  // after the edge that caused them.
  always_comb begin
    live_d       = (state_d == MOVE_R) || (state_d == MOVE_L);
    start_game_d = live_d;
    hittable_r_d = (state_d == MOVE_R) && (pos_d >= WIN_R);
    hittable_l_d = (state_d == MOVE_L) && (pos_d < WIN_L);
    ball_pos_d   = live_d ? (NUM_POS'(1) << pos_d) : '0;
    dir_d        = (state_d == MOVE_R) ? DIR_RIGHT : DIR_LEFT;
    point_l_d    = win_l;
    point_r_d    = win_r;
  end

`ifdef COURT_SPEEDUP_EN
  localparam logic [PW-1:0] PERIOD_FLOOR = PW'(MIN_DIV);

  logic [PW-1:0] period_q, period_d, period_dec;

  always_comb begin
    period_dec = period_q - (period_q >> 3);
    period_d   = period_q;
    if (state_q == POINT) period_d = PERIOD_RST;
    else if (ret_ok)      period_d = (period_dec < PERIOD_FLOOR) ? PERIOD_FLOOR : period_dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) period_q <= PERIOD_RST;
    else     period_q <= period_d;
  end

  assign period = period_q;
`else
  // Fixed step rate; ret_ok only matters when the rally speeds up.
  assign period = PERIOD_RST;
  logic unused_ret_ok;
  assign unused_ret_ok = ret_ok;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pos_q        <= '0;
      start_game_q <= 1'b0;
      hittable_l_q <= 1'b0;
      hittable_r_q <= 1'b0;
      ball_pos_q   <= '0;
      dir_q        <= 1'b0;
      point_l_q    <= 1'b0;
      point_r_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      start_game_q <= start_game_d;
      hittable_l_q <= hittable_l_d;
      hittable_r_q <= hittable_r_d;
      ball_pos_q   <= ball_pos_d;
      dir_q        <= dir_d;
      point_l_q    <= point_l_d;
      point_r_q    <= point_r_d;
    end
  end

  assign start_game = start_game_q;
  assign hittable_l = hittable_l_q;
  assign hittable_r = hittable_r_q;
  assign ball_pos   = ball_pos_q;
  assign dir        = dir_q;
  assign point_l    = point_l_q;
  assign point_r    = point_r_q;

endmodule
